// File: rtl/rf_write_queue.sv
// Register-file write-back queue: merges load and ALU write requests into an
// in-order FIFO and drains one registered Din/WE write per cycle into mem.
module rf_write_queue #(
    parameter int reg_size = 32,
    parameter int mem_size = 32,
    parameter int DEPTH    = 4,
    parameter int AW       = $clog2(mem_size)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AW-1:0]              ld_addr,
    input  logic [reg_size-1:0]        ld_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_addr,
    input  logic [reg_size-1:0]        alu_data,
    input  logic                       hold,
    output logic [reg_size-1:0]        Din,
    output logic [mem_size-1:0]        WE,
    output logic [mem_size-1:0]        pending,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);
    localparam logic [AW:0]   MEM_LIM  = (AW+1)'(mem_size);

    logic [reg_size-1:0] data_q [DEPTH];
    logic [AW-1:0]       addr_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       alu_slot;

    logic ld_acc, alu_acc, ld_bad, alu_bad, ld_push, alu_push, pop;
    logic [CW-1:0] count_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends on occupancy only; a same-edge pop is never counted on.
    assign ld_ready  = (count < DEPTH_C);
    assign alu_ready = (count <= DEPTH_M2) || ((count == DEPTH_M1) && !ld_valid);

    assign ld_acc   = ld_valid && ld_ready;
    assign alu_acc  = alu_valid && alu_ready;
    assign ld_bad   = ({1'b0, ld_addr} >= MEM_LIM);
    assign alu_bad  = ({1'b0, alu_addr} >= MEM_LIM);
    // x0 is hardwired and out-of-range targets are dropped after the handshake.
    assign ld_push  = ld_acc && (ld_addr != '0) && !ld_bad;
    assign alu_push = alu_acc && (alu_addr != '0) && !alu_bad;
    assign pop      = (count != '0) && !hold;

    assign alu_slot   = ld_push ? ptr_inc(wr_ptr) : wr_ptr;
    assign count_next = count + CW'(ld_push) + CW'(alu_push) - CW'(pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (ld_push) begin
            data_q[wr_ptr] <= ld_data;
            addr_q[wr_ptr] <= ld_addr;
        end
        if (alu_push) begin
            data_q[alu_slot] <= alu_data;
            addr_q[alu_slot] <= alu_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            Din    <= '0;
            WE     <= '0;
            err    <= 1'b0;
        end else begin
            // Clear before set: a push never targets the head slot being popped.
            if (pop) vld_q[rd_ptr] <= 1'b0;
            if (ld_push) vld_q[wr_ptr] <= 1'b1;
            if (alu_push) vld_q[alu_slot] <= 1'b1;

            if (ld_push && alu_push) wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (ld_push || alu_push) wr_ptr <= ptr_inc(wr_ptr);

            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                Din    <= data_q[rd_ptr];
                WE     <= mem_size'(1) << addr_q[rd_ptr];
            end else begin
                WE <= '0;
            end

            count <= count_next;
            err   <= err | (ld_acc && ld_bad) | (alu_acc && alu_bad);
        end
    end

    always_comb begin
        pending = WE;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pending = pending | (mem_size'(1) << addr_q[i]);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue; address width is widened to 6 so that
// out-of-range register numbers can be presented.
module tb_rf_write_queue;
    localparam int RS = 32;
    localparam int MS = 32;
    localparam int DP = 4;
    localparam int AWB = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ld_valid, alu_valid, hold;
    logic            ld_ready, alu_ready;
    logic [AWB-1:0]  ld_addr, alu_addr;
    logic [RS-1:0]   ld_data, alu_data;
    logic [RS-1:0]   Din;
    logic [MS-1:0]   WE, pending;
    logic [2:0]      count;
    logic            full, empty, err;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_queue #(.reg_size(RS), .mem_size(MS), .DEPTH(DP), .AW(AWB)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .hold(hold), .Din(Din), .WE(WE), .pending(pending), .count(count),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; alu_valid = 0; ld_addr = '0; alu_addr = '0;
        ld_data = '0; alu_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs(); hold = 0; rst_n = 0;
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty %b full %b want 1 0", empty, full); end
        n_tests++; if (WE !== 32'h0 || Din !== 32'h0) begin n_fail++; $display("FAIL reset_out: WE %h Din %h want 0 0", WE, Din); end
        n_tests++; if (err !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL reset_err_pend: err %b pending %h want 0 0", err, pending); end
        n_tests++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: %b %b want 1 1", ld_ready, alu_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        step();
    endtask

    task automatic test_single();
        alu_valid = 1; alu_addr = 6'd5; alu_data = 32'h0000_1234;
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", alu_ready); end
        step();
        idle_inputs();
        n_tests++; if (count !== 3'd1 || WE !== 32'h0) begin n_fail++; $display("FAIL single_e0: count %0d WE %h want 1 0", count, WE); end
        n_tests++; if (pending !== 32'h20) begin n_fail++; $display("FAIL single_pend0: got %h want 00000020", pending); end
        step();
        n_tests++; if (WE !== 32'h20 || Din !== 32'h0000_1234) begin n_fail++; $display("FAIL single_e1: WE %h Din %h want 00000020 00001234", WE, Din); end
        n_tests++; if (pending !== 32'h20 || count !== 3'd0) begin n_fail++; $display("FAIL single_pend1: pending %h count %0d want 00000020 0", pending, count); end
        step();
        n_tests++; if (WE !== 32'h0 || pending !== 32'h0 || Din !== 32'h0000_1234) begin n_fail++; $display("FAIL single_e2: WE %h pending %h Din %h want 0 0 00001234", WE, pending, Din); end
    endtask

    task automatic test_same_cycle();
        ld_valid = 1; ld_addr = 6'd3; ld_data = 32'hAAAA_0001;
        alu_valid = 1; alu_addr = 6'd4; alu_data = 32'hBBBB_0002;
        step();
        idle_inputs();
        n_tests++; if (count !== 3'd2 || pending !== 32'h18) begin n_fail++; $display("FAIL same_push: count %0d pending %h want 2 00000018", count, pending); end
        step();
        n_tests++; if (WE !== 32'h8 || Din !== 32'hAAAA_0001) begin n_fail++; $display("FAIL same_first: WE %h Din %h want 00000008 aaaa0001", WE, Din); end
        step();
        n_tests++; if (WE !== 32'h10 || Din !== 32'hBBBB_0002 || count !== 3'd0) begin n_fail++; $display("FAIL same_second: WE %h Din %h count %0d want 00000010 bbbb0002 0", WE, Din, count); end
        step();
        n_tests++; if (WE !== 32'h0) begin n_fail++; $display("FAIL same_idle: WE %h want 0", WE); end
    endtask

    task automatic test_fill();
        logic [MS-1:0] exp_we [4];
        exp_we[0] = 32'h2; exp_we[1] = 32'h4; exp_we[2] = 32'h8; exp_we[3] = 32'h10;
        hold = 1;
        ld_valid = 1; ld_addr = 6'd1; ld_data = 32'h1;
        alu_valid = 1; alu_addr = 6'd2; alu_data = 32'h2;
        step();
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL fill_two: count %0d want 2", count); end
        alu_valid = 0; ld_addr = 6'd3; ld_data = 32'h3;
        step();
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL fill_three: count %0d want 3", count); end
        ld_addr = 6'd4; ld_data = 32'h4; alu_valid = 1; alu_addr = 6'd5; alu_data = 32'h5;
        n_tests++; if (alu_ready !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL fill_c3_ready: ld %b alu %b want 1 0", ld_ready, alu_ready); end
        step();
        n_tests++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: count %0d full %b want 4 1", count, full); end
        n_tests++; if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_blocked: ld %b alu %b want 0 0", ld_ready, alu_ready); end
        ld_addr = 6'd6; alu_addr = 6'd7;
        step();
        n_tests++; if (count !== 3'd4 || pending !== 32'h1E || WE !== 32'h0) begin n_fail++; $display("FAIL fill_hold: count %0d pending %h WE %h want 4 0000001e 0", count, pending, WE); end
        idle_inputs(); hold = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (WE !== exp_we[i] || Din !== 32'(i + 1)) begin n_fail++; $display("FAIL fill_drain%0d: WE %h Din %h want %h %h", i, WE, Din, exp_we[i], i + 1); end
        end
        n_tests++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: count %0d empty %b want 0 1", count, empty); end
        step();
        n_tests++; if (WE !== 32'h0) begin n_fail++; $display("FAIL fill_idle: WE %h want 0", WE); end
    endtask

    task automatic test_discard();
        ld_valid = 1; ld_addr = 6'd0; ld_data = 32'hDEAD_BEEF;
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL disc_x0_ready: got %b want 1", ld_ready); end
        step();
        idle_inputs();
        n_tests++; if (count !== 3'd0 || err !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL disc_x0: count %0d err %b pending %h want 0 0 0", count, err, pending); end
        step();
        n_tests++; if (WE !== 32'h0) begin n_fail++; $display("FAIL disc_x0_we: WE %h want 0", WE); end
        alu_valid = 1; alu_addr = 6'd33; alu_data = 32'h1111_2222;
        step();
        idle_inputs();
        n_tests++; if (err !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL disc_range: err %b count %0d want 1 0", err, count); end
        ld_valid = 1; ld_addr = 6'd9; ld_data = 32'h99;
        step();
        idle_inputs();
        step();
        n_tests++; if (WE !== 32'h200 || Din !== 32'h99 || err !== 1'b1) begin n_fail++; $display("FAIL disc_sticky: WE %h Din %h err %b want 00000200 00000099 1", WE, Din, err); end
        step();
    endtask

    task automatic test_dup();
        ld_valid = 1; ld_addr = 6'd7; ld_data = 32'h1;
        step();
        idle_inputs();
        alu_valid = 1; alu_addr = 6'd7; alu_data = 32'h2;
        step();
        idle_inputs();
        n_tests++; if (WE !== 32'h80 || Din !== 32'h1 || pending[7] !== 1'b1) begin n_fail++; $display("FAIL dup_first: WE %h Din %h pend7 %b want 00000080 1 1", WE, Din, pending[7]); end
        step();
        n_tests++; if (WE !== 32'h80 || Din !== 32'h2 || pending[7] !== 1'b1) begin n_fail++; $display("FAIL dup_second: WE %h Din %h pend7 %b want 00000080 2 1", WE, Din, pending[7]); end
        step();
        n_tests++; if (WE !== 32'h0 || pending[7] !== 1'b0) begin n_fail++; $display("FAIL dup_done: WE %h pend7 %b want 0 0", WE, pending[7]); end
    endtask

    task automatic test_reset_mid();
        hold = 0;
        ld_valid = 1; ld_addr = 6'd1; ld_data = 32'h11;
        alu_valid = 1; alu_addr = 6'd2; alu_data = 32'h22;
        step();
        ld_addr = 6'd3; ld_data = 32'h33; alu_addr = 6'd4; alu_data = 32'h44;
        step();
        idle_inputs();
        n_tests++; if (count !== 3'd3 || WE !== 32'h2) begin n_fail++; $display("FAIL mid_pre: count %0d WE %h want 3 00000002", count, WE); end
        #2 rst_n = 0;
        #1;
        n_tests++; if (WE !== 32'h0 || Din !== 32'h0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_reset: WE %h Din %h count %0d want 0 0 0", WE, Din, count); end
        n_tests++; if (empty !== 1'b1 || pending !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_flags: empty %b pending %h err %b want 1 0 0", empty, pending, err); end
        n_tests++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: %b %b want 1 1", ld_ready, alu_ready); end
        @(negedge clk) rst_n = 1;
        step();
        step();
        n_tests++; if (WE !== 32'h0 || count !== 3'd0) begin n_fail++; $display("FAIL mid_after: WE %h count %0d want 0 0", WE, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_fill();
        test_discard();
        test_dup();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
